cacheline_adapter: RTL and testbench

Bridges the pipelined cache's 256-bit line port (dfp_*) to the 64-bit burst memory port (bmem_*). A cache line fill is assembled from four read beats and returned to the cache with a single-cycle dfp_resp. A write-back line is serialized into four write beats. The block also absorbs aborted fills: the cache's allocate state drops dfp_read on branch_mispredict, and the adapter must drain the in-flight burst without responding to it.

---
 rtl/cache_types.sv | 25 ++
 rtl/cacheline_adapter_if.sv | 35 +++
 rtl/cacheline_adapter.sv | 134 +++++++++++++
 tb/tb_cacheline_adapter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types.sv
// Shared types and constants for the cache-to-memory line adapter.
// Build option: ADAPTER_WRITE_EN adds the write-back states to the state enum.
package cache_types;

    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int NUM_BEATS  = LINE_WIDTH / BEAT_WIDTH;
    localparam int BEAT_CNT_W = $clog2(NUM_BEATS);
    localparam int ADDR_WIDTH = 32;
    localparam int OFFSET_W   = $clog2(LINE_WIDTH / 8);
    localparam int TAG_WIDTH  = ADDR_WIDTH - OFFSET_W;

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
`ifdef ADAPTER_WRITE_EN
        RD_DONE,
        WR_BURST,
        WR_DONE
`else
        RD_DONE
`endif
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter_if.sv
// Bundle of the cache line port (dfp_*) and the burst memory port (bmem_*).
// The adapter uses the slave modport; the cache/memory environment uses master.
interface cacheline_adapter_if;
    import cache_types::*;

    logic [ADDR_WIDTH-1:0] dfp_addr;
    logic                  dfp_read;
    logic                  dfp_write;
    logic [LINE_WIDTH-1:0] dfp_wdata;
    logic [LINE_WIDTH-1:0] dfp_rdata;
    logic                  dfp_resp;

    logic [ADDR_WIDTH-1:0] bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [BEAT_WIDTH-1:0] bmem_wdata;
    logic                  bmem_ready;
    logic [BEAT_WIDTH-1:0] bmem_rdata;
    logic                  bmem_rvalid;

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output bmem_ready, bmem_rdata, bmem_rvalid,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  bmem_ready, bmem_rdata, bmem_rvalid,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

endinterface

// File: rtl/cacheline_adapter.sv
// Bridges 256-bit cache line requests to 64-bit memory bursts: four-beat
// fills assembled into one line, four-beat write-backs serialized from one
// line, and fills abandoned by the cache drained without a response.
// Build option: ADAPTER_WRITE_EN enables the write-back path; without it the
// adapter is read-only (instruction cache).
module cacheline_adapter
    import cache_types::*;
(
    input logic          clk,
    input logic          rst,
    cacheline_adapter_if.slave bus
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(NUM_BEATS - 1);

    adapter_state_t        state, state_next;
    logic [BEAT_CNT_W-1:0] cnt, cnt_next;
    logic [LINE_WIDTH-1:0] line, line_next;
    logic [TAG_WIDTH-1:0]  tag, tag_next;

    logic [TAG_WIDTH-1:0]  req_tag;
    assign req_tag = bus.dfp_addr[ADDR_WIDTH-1:OFFSET_W];

    // Byte-offset bits never matter for a line request.
    logic unused_offset;
    assign unused_offset = ^bus.dfp_addr[OFFSET_W-1:0];

`ifndef ADAPTER_WRITE_EN
    // The read-only build has no use for the write-back request.
    logic unused_write;
    assign unused_write = ^{bus.dfp_write, bus.dfp_wdata};
`endif

    // State, beat counter, shared line register and latched line address.
    always_ff @(posedge clk) begin
        // NOTE: the line register is reset too, so a read-back after reset is deterministic.
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            line  <= '0;
            tag   <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state <= state_next;
            cnt   <= cnt_next;
            line  <= line_next;
            tag   <= tag_next;
        end
    end

    // Next-state, datapath next values and all bus outputs.
    always_comb begin
        // NOTE: every output and next value gets a default first, so no path infers a latch.
        state_next     = state;
        cnt_next       = cnt;
        line_next      = line;
        tag_next       = tag;
        bus.dfp_resp   = 1'b0;
        bus.dfp_rdata  = '0;
        bus.bmem_addr  = '0;
        bus.bmem_read  = 1'b0;
        bus.bmem_write = 1'b0;
        bus.bmem_wdata = '0;

        case (state)
            IDLE: begin
`ifdef ADAPTER_WRITE_EN
                if (bus.dfp_write) begin
                    if (bus.bmem_ready) begin
                        bus.bmem_write = 1'b1;
                        bus.bmem_addr  = {req_tag, {OFFSET_W{1'b0}}};
                        bus.bmem_wdata = bus.dfp_wdata[BEAT_WIDTH-1:0];
                        line_next      = bus.dfp_wdata;
                        tag_next       = req_tag;
                        cnt_next       = BEAT_CNT_W'(1);
                        state_next     = WR_BURST;
                    end
                end else
`endif
                if (bus.dfp_read && bus.bmem_ready) begin
                    bus.bmem_read = 1'b1;
                    bus.bmem_addr = {req_tag, {OFFSET_W{1'b0}}};
                    tag_next      = req_tag;
                    cnt_next      = '0;
                    state_next    = RD_BURST;
                end
            end

            // A started burst always runs to its last beat, whatever the cache does.
            RD_BURST: begin
                if (bus.bmem_rvalid) begin
                    line_next[int'(cnt) * BEAT_WIDTH +: BEAT_WIDTH] = bus.bmem_rdata;
                    cnt_next = cnt + 1'b1;
                    if (cnt == LAST_BEAT) begin
                        state_next = RD_DONE;
                    end
                end
            end

            // Respond only if the cache still wants this very line.
            RD_DONE: begin
                if (bus.dfp_read && (req_tag == tag)) begin
                    bus.dfp_resp  = 1'b1;
                    bus.dfp_rdata = line;
                end
                state_next = IDLE;
            end

`ifdef ADAPTER_WRITE_EN
            WR_BURST: begin
                bus.bmem_write = 1'b1;
                bus.bmem_addr  = {tag, {OFFSET_W{1'b0}}};
                bus.bmem_wdata = line[int'(cnt) * BEAT_WIDTH +: BEAT_WIDTH];
                if (bus.bmem_ready) begin
                    cnt_next = cnt + 1'b1;
                    if (cnt == LAST_BEAT) begin
                        state_next = WR_DONE;
                    end
                end
            end

            WR_DONE: begin
                bus.dfp_resp = bus.dfp_write;
                state_next   = IDLE;
            end
`endif

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed, scoreboard-based bench for cacheline_adapter. Expected fill lines,
// responses and write beats are queued as stimulus is driven and checked as
// the adapter produces them. Honours ADAPTER_WRITE_EN for the write tests.
module tb_cacheline_adapter;
    import cache_types::*;

    typedef struct {
        logic                  is_read;
        logic [LINE_WIDTH-1:0] line;
    } exp_resp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_adapter_if bus();

    cacheline_adapter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_resp   = 0;
    int resp_cyc = -1;
    int n_issue  = 0;
    int issue_cyc = -1;
    logic [ADDR_WIDTH-1:0] issue_addr = '0;

    exp_resp_t             resp_q[$];
    logic [BEAT_WIDTH-1:0] wbeat_q[$];

    task automatic check(input string tag, input logic [LINE_WIDTH-1:0] obs,
                         input logic [LINE_WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe the outputs of the current cycle against the scoreboard.
    task automatic monitor();
        exp_resp_t e;
        logic [BEAT_WIDTH-1:0] b;
        if (bus.dfp_resp === 1'b1) begin
            n_resp++;
            resp_cyc = cyc;
            check("resp_expected", resp_q.size() > 0, 1'b1);
            if (resp_q.size() > 0) begin
                e = resp_q.pop_front();
                if (e.is_read) check("fill_line", bus.dfp_rdata, e.line);
            end
        end
        if (bus.bmem_write === 1'b1 && bus.bmem_ready === 1'b1) begin
            check("wbeat_expected", wbeat_q.size() > 0, 1'b1);
            if (wbeat_q.size() > 0) begin
                b = wbeat_q.pop_front();
                check("wbeat_data", bus.bmem_wdata, b);
            end
        end
        if (bus.bmem_read === 1'b1 && bus.bmem_ready === 1'b1) begin
            n_issue++;
            issue_cyc  = cyc;
            issue_addr = bus.bmem_addr;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        bus.dfp_addr    = '0;
        bus.dfp_read    = 1'b0;
        bus.dfp_write   = 1'b0;
        bus.dfp_wdata   = '0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_rdata  = '0;
        bus.bmem_rvalid = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_resp"},   bus.dfp_resp,   1'b0);
        check({tag, "_rdata"},  bus.dfp_rdata,  '0);
        check({tag, "_bread"},  bus.bmem_read,  1'b0);
        check({tag, "_bwrite"}, bus.bmem_write, 1'b0);
        check({tag, "_baddr"},  bus.bmem_addr,  '0);
        check({tag, "_bwdata"}, bus.bmem_wdata, '0);
    endtask

    // Issue a fill, return beats seed+0..3 on the cycles set in mask (bit i = T+i).
    task automatic run_fill(input logic [ADDR_WIDTH-1:0] addr, input logic [15:0] mask,
                            input logic [BEAT_WIDTH-1:0] seed, input int lat);
        exp_resp_t e;
        int t0, r0, k;
        e.is_read = 1'b1;
        for (int j = 0; j < NUM_BEATS; j++) e.line[j*BEAT_WIDTH +: BEAT_WIDTH] = seed + BEAT_WIDTH'(j);
        resp_q.push_back(e);
        bus.dfp_addr   = addr;
        bus.dfp_read   = 1'b1;
        bus.bmem_ready = 1'b1;
        t0 = cyc;
        r0 = n_resp;
        k  = 0;
        tick();
        check("fill_issue_cyc", issue_cyc, t0);
        check("fill_bmem_addr", issue_addr, {addr[31:5], 5'b0});
        for (int i = 1; i < 16; i++) begin
            bus.bmem_rvalid = mask[i];
            bus.bmem_rdata  = mask[i] ? seed + BEAT_WIDTH'(k) : 64'hBAD0_BAD0_BAD0_BAD0;
            if (mask[i]) k++;
            tick();
            if (n_resp != r0) bus.dfp_read = 1'b0;
        end
        bus.bmem_rvalid = 1'b0;
        check("fill_resp_cyc", resp_cyc, t0 + lat);
        check("fill_resp_count", n_resp - r0, 1);
    endtask

    initial begin
        exp_resp_t e;
        int t0, r0, i0, first_cyc;
        logic [LINE_WIDTH-1:0] wline;

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        sample();
        check_quiet("reset");
        advance();
        rst = 1'b0;
        tick();

        // Basic fill with back-to-back beats.
        run_fill(32'h1234_5678, 16'h001E, 64'h0, 5);
        check("basic_addr_const", issue_addr, 32'h1234_5660);
        tick();

        // Gapped beats at T+3, T+4, T+7, T+9.
        run_fill(32'h0000_0040, 16'h0298, 64'h1111_0000_0000_0010, 10);
        tick();

        // Aborted fill, then a new line requested mid-burst.
        t0 = cyc; r0 = n_resp; i0 = n_issue;
        e.is_read = 1'b1;
        for (int j = 0; j < NUM_BEATS; j++) e.line[j*BEAT_WIDTH +: BEAT_WIDTH] = 64'h5555_0000_0000_0000 + BEAT_WIDTH'(j);
        resp_q.push_back(e);
        bus.dfp_addr   = 32'h0000_4440;
        bus.dfp_read   = 1'b1;
        bus.bmem_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i == 2) bus.dfp_read = 1'b0;
            if (i == 3) begin
                bus.dfp_read = 1'b1;
                bus.dfp_addr = 32'h2000_0000;
            end
            bus.bmem_rvalid = ((i >= 1) && (i <= 4)) || ((i >= 7) && (i <= 10));
            bus.bmem_rdata  = (i <= 4) ? 64'hAB00 + BEAT_WIDTH'(i) : 64'h5555_0000_0000_0000 + BEAT_WIDTH'(i - 7);
            tick();
            if (i >= 3 && n_resp != r0) bus.dfp_read = 1'b0;
        end
        bus.bmem_rvalid = 1'b0;
        check("abort_issue_count", n_issue - i0, 2);
        check("abort_reissue_cyc", issue_cyc, t0 + 6);
        check("abort_reissue_addr", issue_addr, 32'h2000_0000);
        check("abort_resp_cyc", resp_cyc, t0 + 11);
        check("abort_resp_count", n_resp - r0, 1);
        tick();

        // Reset in the middle of a fill, followed by stray beats.
        r0 = n_resp;
        bus.dfp_addr   = 32'h0000_1000;
        bus.dfp_read   = 1'b1;
        bus.bmem_ready = 1'b1;
        tick();
        bus.bmem_rvalid = 1'b1;
        bus.bmem_rdata  = 64'h77;
        tick();
        rst          = 1'b1;
        bus.dfp_read = 1'b0;
        tick();
        rst            = 1'b0;
        bus.bmem_rdata = 64'h88;
        sample();
        check_quiet("post_reset");
        advance();
        bus.bmem_rdata = 64'h99;
        sample();
        check_quiet("stray_beat");
        advance();
        bus.bmem_rvalid = 1'b0;
        check("reset_no_resp", n_resp - r0, 0);
        run_fill(32'h0000_1000, 16'h001E, 64'hC0DE_0000_0000_0000, 5);
        tick();

`ifdef ADAPTER_WRITE_EN
        // Write-back with one stalled beat at T+1.
        wline = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                 64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
        t0 = cyc; r0 = n_resp;
        e.is_read = 1'b0;
        e.line    = '0;
        resp_q.push_back(e);
        for (int j = 0; j < NUM_BEATS; j++) wbeat_q.push_back(wline[j*BEAT_WIDTH +: BEAT_WIDTH]);
        bus.dfp_write = 1'b1;
        bus.dfp_wdata = wline;
        bus.dfp_addr  = 32'h0000_8024;
        for (int i = 0; i < 9; i++) begin
            bus.bmem_ready = (i != 1);
            sample();
            if (i == 1) begin
                check("wr_hold_valid", bus.bmem_write, 1'b1);
                check("wr_hold_data", bus.bmem_wdata, 64'hA1A1_A1A1_0000_0001);
            end
            if (i <= 4) check("wr_addr", bus.bmem_addr, 32'h0000_8020);
            advance();
            if (n_resp != r0) bus.dfp_write = 1'b0;
        end
        check("wr_resp_cyc", resp_cyc, t0 + 5);
        check("wr_resp_count", n_resp - r0, 1);
        check("wr_beats_drained", wbeat_q.size(), 0);
        tick();

        // Read and write together: write first, read right after its response.
        wline = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
        t0 = cyc; r0 = n_resp; first_cyc = -1;
        e.is_read = 1'b0;
        e.line    = '0;
        resp_q.push_back(e);
        for (int j = 0; j < NUM_BEATS; j++) wbeat_q.push_back(wline[j*BEAT_WIDTH +: BEAT_WIDTH]);
        e.is_read = 1'b1;
        for (int j = 0; j < NUM_BEATS; j++) e.line[j*BEAT_WIDTH +: BEAT_WIDTH] = 64'hD000 + BEAT_WIDTH'(j);
        resp_q.push_back(e);
        bus.dfp_write  = 1'b1;
        bus.dfp_read   = 1'b1;
        bus.dfp_wdata  = wline;
        bus.dfp_addr   = 32'h0000_9000;
        bus.bmem_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bus.bmem_rvalid = (i >= 6) && (i <= 9);
            bus.bmem_rdata  = 64'hD000 + BEAT_WIDTH'(i - 6);
            tick();
            if (n_resp - r0 == 1 && first_cyc < 0) begin
                first_cyc     = resp_cyc;
                bus.dfp_write = 1'b0;
            end
            if (n_resp - r0 == 2) bus.dfp_read = 1'b0;
        end
        bus.bmem_rvalid = 1'b0;
        check("rw_write_resp_cyc", first_cyc, t0 + 4);
        check("rw_read_issue_cyc", issue_cyc, t0 + 5);
        check("rw_read_resp_cyc", resp_cyc, t0 + 10);
        check("rw_resp_count", n_resp - r0, 2);
        tick();
`else
        // Read-only build: write requests are ignored entirely.
        r0 = n_resp;
        bus.dfp_write  = 1'b1;
        bus.dfp_wdata  = {4{64'hFEED_FACE_0000_0001}};
        bus.dfp_addr   = 32'h0000_8000;
        bus.bmem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("ro_bwrite", bus.bmem_write, 1'b0);
            check("ro_bwdata", bus.bmem_wdata, '0);
            check("ro_bread", bus.bmem_read, 1'b0);
            advance();
        end
        check("ro_no_resp", n_resp - r0, 0);
        // Read alongside an ignored write issues immediately.
        run_fill(32'h0000_9000, 16'h001E, 64'hD000, 5);
        bus.dfp_write = 1'b0;
        tick();
`endif

        check("resp_q_drained", resp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
